// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the HI/LO multiply/divide unit.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_RUN  = 1'b1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_pair_t;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply and divide datapath producing a 64-bit HI/LO pair.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_s;
    logic [31:0] div_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        b_zero;

    assign b_zero = (b == 32'd0);
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps instead of overflowing.
    assign abs_a  = a[31] ? -a : a;
    assign abs_b  = b[31] ? -b : b;
    assign div_s  = b_zero ? 32'd1 : abs_b;
    assign div_u  = b_zero ? 32'd1 : b;
    assign q_mag  = abs_a / div_s;
    assign r_mag  = abs_a % div_s;
    assign quot_u = a / div_u;
    assign rem_u  = a % div_u;

    always_comb begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
        case (mdop)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                div_by_zero = b_zero;
                res_lo      = (a[31] ^ b[31]) ? -q_mag : q_mag;
                res_hi      = a[31] ? -r_mag : r_mag;
            end
            MD_DIVU: begin
                div_by_zero = b_zero;
                res_lo      = quot_u;
                res_hi      = rem_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit answering the decode Start/Busy handshake.
//  state   | meaning
//  MD_IDLE | waiting for Start; MTHI/MTLO write HI/LO directly
//  MD_RUN  | result staged, counting down to commit; Start ignored
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    md_pair_t      staged;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          div_by_zero;

    md_arith u_arith (
        .mdop        (MDop),
        .a           (A),
        .b           (B),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    assign Busy = (state == MD_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            staged <= '0;
            HI     <= 32'd0;
            LO     <= 32'd0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (Start) begin
                        case (MDop)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                // Divide by zero re-stages the current pair so commit is a no-op.
                                staged.hi <= div_by_zero ? HI : res_hi;
                                staged.lo <= div_by_zero ? LO : res_lo;
                                cnt       <= md_is_div(MDop) ? DIV_LOAD : MULT_LOAD;
                                state     <= MD_RUN;
                            end
                            MD_MTHI: HI <= A;
                            MD_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        HI    <= staged.hi;
                        LO    <= staged.lo;
                        state <= MD_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, corner sequences, random ops vs model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .Start (start),
        .MDop  (mdop),
        .A     (a),
        .B     (b),
        .Busy  (busy),
        .HI    (hi),
        .LO    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Expected HI/LO and latency from the arithmetic rules, using 64-bit integer math.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                                      input logic [31:0] hi_in, input logic [31:0] lo_in,
                                      output logic [31:0] hi_out, output logic [31:0] lo_out,
                                      output int lat);
        longint      sa;
        longint      sb;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] pu;
        sa = longint'($signed(xa));
        sb = longint'($signed(xb));
        hi_out = hi_in;
        lo_out = lo_in;
        lat = 0;
        case (op)
            3'd0: begin
                p = sa * sb;
                hi_out = p[63:32];
                lo_out = p[31:0];
                lat = 5;
            end
            3'd1: begin
                pu = {32'd0, xa} * {32'd0, xb};
                hi_out = pu[63:32];
                lo_out = pu[31:0];
                lat = 5;
            end
            3'd2: begin
                if (xb != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    lo_out = q[31:0];
                    hi_out = r[31:0];
                end
                lat = 10;
            end
            3'd3: begin
                if (xb != 0) begin
                    lo_out = xa / xb;
                    hi_out = xa % xb;
                end
                lat = 10;
            end
            3'd4: hi_out = xa;
            3'd5: lo_out = xa;
            default: ;
        endcase
    endfunction

    // Issue one op at the current negedge, then count Busy cycles, checking HI/LO hold exp_* meanwhile.
    task automatic run_op(input logic [2:0] op, input logic [31:0] xa, input logic [31:0] xb,
                          output int cycles, output logic held);
        start = 1'b1;
        mdop  = op;
        a     = xa;
        b     = xb;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        held = 1'b1;
        @(negedge clk);
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int          cyc;
        logic        held;
        logic [31:0] nh;
        logic [31:0] nl;
        int          lat;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd4, 32'h12345678, 32'h00000000, 32'h12345678, 32'h00000003, 0};
        vecs[5]  = '{3'd2, 32'h00000005, 32'h00000000, 32'h12345678, 32'h00000003, 10};
        vecs[6]  = '{3'd5, 32'hCAFEBABE, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 0};
        vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[8]  = '{3'd6, 32'h55555555, 32'h00000003, 32'h00000000, 32'h80000000, 0};
        vecs[9]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
        vecs[11] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};

        reset = 1'b0;
        start = 1'b0;
        mdop  = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed table, issued back-to-back: each Start lands in the first cycle Busy reads 0.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, held);
            check($sformatf("vec%0d_lat", i), cyc, vecs[i].lat);
            check($sformatf("vec%0d_hold", i), {31'd0, held}, 32'd1);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            exp_hi = vecs[i].hi;
            exp_lo = vecs[i].lo;
        end

        // Reset mid-count discards the in-flight multiply and clears HI/LO at once.
        run_op(3'd4, 32'hA5A5A5A5, 32'd0, cyc, held);
        exp_hi = 32'hA5A5A5A5;
        check("mthi_pre_reset", hi, exp_hi);
        start = 1'b1;
        mdop  = 3'd0;
        a     = 32'd3;
        b     = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("postreset_busy", {31'd0, busy}, 32'd0);
        check("postreset_hi", hi, 32'd0);
        check("postreset_lo", lo, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;

        // Start re-pulsed (MULT, then MTHI) while Busy: ignored, original timing and result kept.
        start = 1'b1;
        mdop  = 3'd0;
        a     = 32'h10;
        b     = 32'h20;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        @(negedge clk);
        if (busy === 1'b1) cyc++;
        start = 1'b1;
        mdop  = 3'd0;
        a     = 32'd7;
        b     = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        if (busy === 1'b1) cyc++;
        start = 1'b1;
        mdop  = 3'd4;
        a     = 32'hDEADBEEF;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("ignore_lat", cyc, 5);
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'h200);
        exp_lo = 32'h200;

        // Random ops against the reference model.
        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            ref_model(rop, ra, rb, exp_hi, exp_lo, nh, nl, lat);
            run_op(rop, ra, rb, cyc, held);
            check($sformatf("rnd%0d_op%0d_lat", n, rop), cyc, lat);
            check($sformatf("rnd%0d_op%0d_hold", n, rop), {31'd0, held}, 32'd1);
            check($sformatf("rnd%0d_op%0d_hi", n, rop), hi, nh);
            check($sformatf("rnd%0d_op%0d_lo", n, rop), lo, nl);
            exp_hi = nh;
            exp_lo = nl;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit in the EX stage. It is the responder to the decode stage's Start/Busy handshake.
- Accepts one operation per Start pulse and holds Busy for a fixed latency. HI/LO update only when the operation retires.
- Decode stalls any HI/LO-related instruction while Busy=1 or Start=1; this block relies on that stall.

Parameters:
MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (>=1)
DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
Start  input  1  single-cycle request; qualifies MDop/A/B in the same cycle
MDop  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
A  input  32  forwarded rs value (multiplicand/dividend, or MTHI/MTLO source)
B  input  32  forwarded rt value (multiplier/divisor)
Busy  output  1  high while a mult/div is in flight
HI  output  32  HI register (registered)
LO  output  32  LO register (registered)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, Busy=0, HI=0, LO=0, counter=0, staged results=0. An in-flight operation is discarded. No commit occurs on the first clock edge after reset is released.
- States: IDLE and RUN. A down-counter of width clog2(max(MULT_CYCLES, DIV_CYCLES))+1 tracks the remaining cycles.
- IDLE, Start=1, MDop in 0-3:
  - Compute the 64-bit result combinationally from A and B and latch it into the staged hi/lo registers.
  - counter <= MULT_CYCLES or DIV_CYCLES; Busy <= 1; state <= RUN.
- IDLE, Start=1, MDop=4: HI <= A at this edge, no Busy. MDop=5: LO <= A, no Busy.
- IDLE, Start=1, MDop 6-7: no effect.
- RUN, each edge: counter decrements. At the edge where counter==1: HI/LO <= staged values, Busy <= 0, state <= IDLE.
- Result: Busy is high for exactly N cycles after the Start edge. The new HI/LO are visible in the cycle Busy first reads 0.
- Start while Busy=1 or while in RUN is ignored, including MTHI/MTLO. This is a protocol violation: decode never issues it.
- Start is accepted in the cycle immediately after Busy falls (back-to-back operations).
- Arithmetic:
  - MULT: signed 32x32 -> 64, HI=product[63:32], LO=product[31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- DIV/DIVU with B=0: the full latency is observed and HI/LO are left unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- HI and LO are read directly by the EX-stage mfhi/mflo mux. They are stable throughout RUN and hold the previous values.

Decomposition:
- Shared package (md_pkg):
  - MDop encodings MD_MULT..MD_MTLO.
  - Default latencies MD_MULT_CYCLES=5 and MD_DIV_CYCLES=10.
  - State encoding MD_IDLE/MD_RUN.
- One natural sub-module: md_arith, purely combinational. Inputs: MDop, A, B. Outputs: res_hi, res_lo, div_by_zero. The FSM, counter and registers stay in mult_div_unit.

Test Plan:
- MULT A=0xFFFFFFFF B=0x00000002 -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7) B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7 B=2 -> LO=3, HI=1, issued back-to-back with the next Start accepted in the first cycle Busy=0.
- MTHI A=0x12345678, then DIV A=5 B=0 -> HI=0x12345678 one edge after MTHI. Busy high for 10 cycles; HI/LO unchanged.
- Start MULT, assert reset=0 mid-count (cycle 3) -> Busy, HI, LO all 0 immediately. Start MULT re-pulsed while Busy=1 -> ignored, the original completion time is kept.
